// File: rtl/multicycle_controller.sv
// multicycle_controller
//
// Multi-cycle control sequencer for the R4 RV32I core. It steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB and shares a single memory port
// between instruction fetch and load/store data access. This block decides
// only *when* the PC/IR/MDR/register-file enables fire. The combinational
// decoder still selects the ALU operation and the operands.
//
// Parameters
//   TIMEOUT        : maximum number of cycles to wait for mem_ready in FETCH or
//                    MEM. 0 disables the timeout.
//
// Ports
//   clk            : clock; all state updates on the rising edge
//   reset          : synchronous, active-high
//   instr[31:0]    : current IR contents; only instr[6:0] is used
//   branch_taken   : ALU compare result, valid in EXEC
//   mem_ready      : memory completes the current request this cycle
//   mem_req        : memory request
//   mem_we         : write strobe, qualified by mem_req
//   mem_addr_sel   : 0 = PC, 1 = ALU result
//   ir_load        : capture memory read data into IR
//   mdr_load       : capture memory read data into MDR
//   pc_write       : update PC
//   pc_src         : 0 = PC+4, 1 = branch target
//   reg_write      : register-file write enable
//   mem_to_reg     : writeback source; 1 = MDR, 0 = ALU
//   retire         : one-cycle pulse per completed instruction
//   fault          : sticky; illegal opcode or timeout
//   fault_timeout  : sticky; the fault came from a timeout
//   state[2:0]     : FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 FAULT=5
//   instret[31:0]  : retired-instruction count
//
// Build option
//   MULTICYCLE_CTRL_PERF_EN : when defined, instret counts retire pulses and
//                             wraps at 2^32. Otherwise instret is tied to 0
//                             and no counter register is built.

module multicycle_controller #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_load,
    output logic        mdr_load,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        retire,
    output logic        fault,
    output logic        fault_timeout,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_B    = 7'b1100011;

    // Wait counter is at least 8 bits and wide enough to hold TIMEOUT.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    // Value of the counter during the wait cycle that brings it to TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t           cur_state;
    state_t           nxt_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_expired;
    logic             to_timeout;

    logic [6:0] opcode;
    logic       is_lw;
    logic       is_sw;
    logic       is_b;
    logic       is_legal;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign unused_instr = ^instr[31:7];
    assign is_lw        = (opcode == OP_LW);
    assign is_sw        = (opcode == OP_SW);
    assign is_b         = (opcode == OP_B);
    assign is_legal     = is_lw || is_sw || is_b || (opcode == OP_ADDI) || (opcode == OP_R);

    // Asserted in the wait cycle that makes the count reach TIMEOUT. A
    // mem_ready in that same cycle still completes the request.
    assign wait_expired = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

    assign state = cur_state;
    assign fault = (cur_state == S_FAULT);

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state     <= S_FETCH;
            wait_cnt      <= '0;
            fault_timeout <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            // Every entry into FETCH or MEM is a state change, so clearing on
            // any change gives each memory request a fresh count.
            if (nxt_state != cur_state) begin
                wait_cnt <= '0;
            end else if (mem_req && !mem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (to_timeout) begin
                fault_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        nxt_state    = cur_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        mdr_load     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        retire       = 1'b0;
        to_timeout   = 1'b0;

        case (cur_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load   = 1'b1;
                    nxt_state = S_DECODE;
                end else if (wait_expired) begin
                    to_timeout = 1'b1;
                    nxt_state  = S_FAULT;
                end
            end
            S_DECODE: begin
                nxt_state = is_legal ? S_EXEC : S_FAULT;
            end
            S_EXEC: begin
                if (is_b) begin
                    pc_write  = 1'b1;
                    pc_src    = branch_taken;
                    retire    = 1'b1;
                    nxt_state = S_FETCH;
                end else if (is_lw || is_sw) begin
                    nxt_state = S_MEM;
                end else begin
                    nxt_state = S_WB;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        pc_write  = 1'b1;
                        retire    = 1'b1;
                        nxt_state = S_FETCH;
                    end else begin
                        mdr_load  = 1'b1;
                        nxt_state = S_WB;
                    end
                end else if (wait_expired) begin
                    to_timeout = 1'b1;
                    nxt_state  = S_FAULT;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_lw;
                pc_write   = 1'b1;
                retire     = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_FAULT: begin
                nxt_state = S_FAULT;
            end
            default: begin
                nxt_state = S_FAULT;
            end
        endcase
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_load, mdr_load;
    logic        pc_write, pc_src, reg_write, mem_to_reg, retire;
    logic        fault, fault_timeout;
    logic [2:0]  state;
    logic [31:0] instret;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_load      (ir_load),
        .mdr_load     (mdr_load),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .retire       (retire),
        .fault        (fault),
        .fault_timeout(fault_timeout),
        .state        (state),
        .instret      (instret)
    );

    // Output snapshot:
    // [14]req [13]we [12]addr_sel [11]ir_load [10]mdr_load [9]pc_write
    // [8]pc_src [7]reg_write [6]mem_to_reg [5]retire [4]fault
    // [3]fault_timeout [2:0]state
    logic [14:0] obs;
    assign obs = {mem_req, mem_we, mem_addr_sel, ir_load, mdr_load, pc_write,
                  pc_src, reg_write, mem_to_reg, retire, fault, fault_timeout, state};

    localparam logic [14:0] X_FETCH_WAIT  = 15'h4000;
    localparam logic [14:0] X_FETCH_RDY   = 15'h4800;
    localparam logic [14:0] X_DECODE      = 15'h0001;
    localparam logic [14:0] X_EXEC        = 15'h0002;
    localparam logic [14:0] X_BR_T        = 15'h0322;
    localparam logic [14:0] X_BR_NT       = 15'h0222;
    localparam logic [14:0] X_MEM_LD_WAIT = 15'h5003;
    localparam logic [14:0] X_MEM_LD_RDY  = 15'h5403;
    localparam logic [14:0] X_MEM_ST_WAIT = 15'h7003;
    localparam logic [14:0] X_MEM_ST_RDY  = 15'h7223;
    localparam logic [14:0] X_WB_ALU      = 15'h02A4;
    localparam logic [14:0] X_WB_LD       = 15'h02E4;
    localparam logic [14:0] X_FAULT_OP    = 15'h0015;
    localparam logic [14:0] X_FAULT_TO    = 15'h001D;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BEQ  = 32'h00208063;
    localparam logic [31:0] I_LUI  = 32'h000000B7;

    task automatic test_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== X_FETCH_WAIT) begin
            failures++;
            $display("FAIL reset_outputs obs=%h exp=%h", obs, X_FETCH_WAIT);
        end
        checks++;
        if (instret !== 32'd0) begin
            failures++;
            $display("FAIL reset_instret obs=%0d exp=0", instret);
        end
    endtask

    task automatic test_add();
        logic [14:0] e [0:3];
        e = '{X_FETCH_RDY, X_DECODE, X_EXEC, X_WB_ALU};
        instr = I_ADD;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1; branch_taken = 1'b0; #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL add cyc%0d obs=%h exp=%h", i, obs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        logic [14:0] e [0:6];
        logic        r [0:6];
        e = '{X_FETCH_RDY, X_DECODE, X_EXEC, X_MEM_LD_WAIT, X_MEM_LD_WAIT, X_MEM_LD_RDY, X_WB_LD};
        r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        instr = I_LW;
        for (int i = 0; i < 7; i++) begin
            mem_ready = r[i]; branch_taken = 1'b0; #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL lw_wait cyc%0d obs=%h exp=%h", i, obs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw();
        logic [14:0] e [0:4];
        logic        r [0:4];
        e = '{X_FETCH_RDY, X_DECODE, X_EXEC, X_MEM_ST_WAIT, X_MEM_ST_RDY};
        r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        instr = I_SW;
        for (int i = 0; i < 5; i++) begin
            mem_ready = r[i]; branch_taken = 1'b0; #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL sw cyc%0d obs=%h exp=%h", i, obs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch(input logic taken);
        logic [14:0] e [0:2];
        e = '{X_FETCH_RDY, X_DECODE, taken ? X_BR_T : X_BR_NT};
        instr = I_BEQ;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1; branch_taken = taken; #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL beq_taken%0d cyc%0d obs=%h exp=%h", taken, i, obs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [14:0] e [0:3];
        e = '{X_FETCH_RDY, X_DECODE, X_FAULT_OP, X_FAULT_OP};
        instr = I_LUI;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1; branch_taken = 1'b0; #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL illegal cyc%0d obs=%h exp=%h", i, obs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        logic [14:0] e [0:5];
        e = '{X_FETCH_WAIT, X_FETCH_WAIT, X_FETCH_WAIT, X_FETCH_WAIT, X_FAULT_TO, X_FAULT_TO};
        instr = I_ADD;
        for (int i = 0; i < 6; i++) begin
            mem_ready = 1'b0; branch_taken = 1'b0; #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL timeout cyc%0d obs=%h exp=%h", i, obs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ready_wins();
        logic [14:0] e [0:6];
        logic        r [0:6];
        e = '{X_FETCH_WAIT, X_FETCH_WAIT, X_FETCH_WAIT, X_FETCH_RDY, X_DECODE, X_EXEC, X_WB_ALU};
        r = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        instr = I_ADD;
        for (int i = 0; i < 7; i++) begin
            mem_ready = r[i]; branch_taken = 1'b0; #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL ready_wins cyc%0d obs=%h exp=%h", i, obs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mid_mem_reset();
        logic [14:0] e [0:3];
        logic        r [0:3];
        e = '{X_FETCH_RDY, X_DECODE, X_EXEC, X_MEM_LD_WAIT};
        r = '{1'b1, 1'b1, 1'b1, 1'b0};
        instr = I_LW;
        for (int i = 0; i < 4; i++) begin
            mem_ready = r[i]; branch_taken = 1'b0; #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL mid_reset cyc%0d obs=%h exp=%h", i, obs, e[i]);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1; mem_ready = 1'b0; #1;
        checks++;
        if (obs !== X_MEM_LD_WAIT) begin
            failures++;
            $display("FAIL mid_reset_hold obs=%h exp=%h", obs, X_MEM_LD_WAIT);
        end
        @(posedge clk); #1;
        reset = 1'b0; #1;
        checks++;
        if (obs !== X_FETCH_WAIT) begin
            failures++;
            $display("FAIL mid_reset_after obs=%h exp=%h", obs, X_FETCH_WAIT);
        end
    endtask

    task automatic test_instret();
        logic [31:0] exp_cnt;
        instr = I_BEQ;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 3; i++) begin
                mem_ready = 1'b1; branch_taken = 1'b0; #1;
                checks++;
                if (obs !== ((i == 0) ? X_FETCH_RDY : (i == 1) ? X_DECODE : X_BR_NT)) begin
                    failures++;
                    $display("FAIL instret_seq n%0d cyc%0d obs=%h", n, i, obs);
                end
                @(posedge clk); #1;
            end
        end
`ifdef MULTICYCLE_CTRL_PERF_EN
        exp_cnt = 32'd5;
`else
        exp_cnt = 32'd0;
`endif
        checks++;
        if (instret !== exp_cnt) begin
            failures++;
            $display("FAIL instret obs=%0d exp=%0d", instret, exp_cnt);
        end
    endtask

    initial begin
        reset        = 1'b1;
        instr        = 32'd0;
        branch_taken = 1'b0;
        mem_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_add();
        test_lw_wait();
        test_sw();
        test_branch(1'b1);
        test_branch(1'b0);
        test_illegal();
        test_reset();
        test_timeout();
        test_reset();
        test_ready_wins();
        test_mid_mem_reset();
        test_reset();
        test_instret();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control sequencer for the R4 RV32I core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and shares one memory port between instruction fetch and load/store data access. It drives the PC, IR, MDR and register-file enables plus the memory handshake. The combinational decoder still supplies ALU operation and operand selection from the IR contents; this block owns only *when* each enable fires.

## Interface
- `TIMEOUT`, default 255: maximum wait cycles for `mem_ready` in FETCH or MEM. A value of 0 disables the timeout.
- `clk` in 1: clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `instr` in 32: current IR contents. Only `instr[6:0]` is used for classification.
- `branch_taken` in 1: ALU compare result, valid in EXEC.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write strobe, qualified by `mem_req`.
- `mem_addr_sel` out 1: memory address select. 0 selects PC, 1 selects the ALU result.
- `ir_load` out 1: capture memory read data into IR.
- `mdr_load` out 1: capture memory read data into MDR.
- `pc_write` out 1: update PC.
- `pc_src` out 1: PC source. 0 selects PC+4, 1 selects the branch target.
- `reg_write` out 1: register-file write enable.
- `mem_to_reg` out 1: writeback source. 1 selects MDR, 0 selects ALU.
- `retire` out 1: one-cycle pulse per completed instruction.
- `fault` out 1: sticky; set by an illegal opcode or a timeout.
- `fault_timeout` out 1: sticky; 1 when the fault was caused by a timeout.
- `state` out 3: encoded state for debug.
  - FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5.
- `instret` out 32: retired-instruction count. See Configuration.

## Operation
Legal opcodes:
- LW 0000011
- SW 0100011
- ADDI 0010011
- R 0110011
- B 1100011

Every other opcode is illegal.

State behaviour:
- **FETCH**
  - Drives `mem_req`=1, `mem_addr_sel`=0, `mem_we`=0.
  - When `mem_ready`=1: drives `ir_load`=1 in the same cycle and goes to DECODE.
- **DECODE**
  - One cycle with all enables 0.
  - Illegal opcode goes to FAULT. Any legal opcode goes to EXEC.
- **EXEC**
  - One cycle.
  - ADDI and R go to WB. LW and SW go to MEM.
  - B drives `pc_write`=1, `pc_src`=`branch_taken`, `retire`=1, then goes to FETCH.
- **MEM**
  - Drives `mem_req`=1, `mem_addr_sel`=1, `mem_we`=(opcode==SW).
  - On `mem_ready` for SW: `pc_write`=1, `pc_src`=0, `retire`=1, then FETCH.
  - On `mem_ready` for LW: `mdr_load`=1, then WB.
- **WB**
  - Drives `reg_write`=1, `mem_to_reg`=(opcode==LW), `pc_write`=1, `pc_src`=0, `retire`=1, then FETCH.
- **FAULT**
  - Terminal until `reset`. All enables and `retire` are 0; `fault`=1.

Wait counter (8+ bits, sized to hold `TIMEOUT`):
- Clears on entry to FETCH or MEM.
- Increments each cycle `mem_req`=1 and `mem_ready`=0.
- When the count equals `TIMEOUT` with `mem_ready`=0, go to FAULT and set `fault_timeout`=1.
- If `mem_ready`=1 in the same cycle the count reaches `TIMEOUT`, ready wins.
- `TIMEOUT`=0 disables the counter.

Output timing classes:
- Enables are Moore outputs of the state.
- `ir_load`, `mdr_load`, and the `pc_write`/`retire` in MEM are Mealy outputs on `mem_ready`.
- `mem_ready` is ignored when `mem_req`=0.

## Timing
Reset:
- After the reset edge: state=FETCH, counter=0, `fault`=0, `fault_timeout`=0, `instret`=0.
- Consequently `mem_req`=1 and every other output is 0 in the first cycle after reset.
- Reset mid-transaction abandons the request. The memory must tolerate `mem_req` dropping without `mem_ready`.

Cycles per instruction with zero-wait memory (`mem_ready` high in the first request cycle):
- R/ADDI: 4
- LW: 5
- SW: 4
- B: 3

Each memory wait cycle adds 1.

Invariants:
- At most one of `ir_load`/`mdr_load` per cycle.
- `retire` and `pc_write` always coincide.

`instret` wraps from 0xFFFFFFFF to 0.

## Configuration
- Macro: `MULTICYCLE_CTRL_PERF_EN`.
- Defined: `instret` increments on every `retire` pulse and is cleared by `reset`.
- Undefined: `instret` is constant 0 and no counter register is instantiated. The port is still present.

## Test plan
- **Zero-wait ADD** (`instr`=0x002081B3, `mem_ready`=1):
  - States 0→1→2→4→0.
  - `reg_write`=1, `mem_to_reg`=0, `retire`=1 in WB only.
  - 4 cycles per retire.
- **LW with 2 wait cycles in MEM:**
  - MEM is held for 3 cycles and `mdr_load` pulses on the third.
  - WB has `mem_to_reg`=1.
  - Total 7 cycles.
- **SW:**
  - `mem_we`=1 only in MEM.
  - Retire on the `mem_ready` cycle with no WB state and no `reg_write`.
- **BEQ:**
  - `branch_taken`=1 gives `pc_src`=1 in EXEC.
  - `branch_taken`=0 gives `pc_src`=0.
  - Each takes 3 cycles.
- **Fault paths:**
  - Opcode 0110111 → FAULT after DECODE; `fault`=1, `fault_timeout`=0.
  - `TIMEOUT`=4 with `mem_ready` held low in FETCH → FAULT after the 4th wait cycle; `fault_timeout`=1.
  - `reset` from FAULT → FETCH with all flags cleared.
- **Mid-fetch reset and wrap:**
  - `reset` during a MEM wait → FETCH next cycle, no retire.
  - With `MULTICYCLE_CTRL_PERF_EN` defined, 5 retires give `instret`=5.
